// File: rtl/line_stepper_if.sv
// Command/response bundle between the plot sequencer and line_stepper:
// segment request in, per-tick axis step commands and pen state out.
interface line_stepper_if #(
  parameter int W = 9
);
  logic         tick;
  logic         start;
  logic         pen;
  logic [W-1:0] x0;
  logic [W-1:0] y0;
  logic [W-1:0] x1;
  logic [W-1:0] y1;
  logic [1:0]   dirx;
  logic [1:0]   diry;
  logic         pen_down;
  logic [W-1:0] cur_x;
  logic [W-1:0] cur_y;
  logic         busy;
  logic         done;

  modport master (
    output tick, start, pen, x0, y0, x1, y1,
    input  dirx, diry, pen_down, cur_x, cur_y, busy, done
  );

  modport slave (
    input  tick, start, pen, x0, y0, x1, y1,
    output dirx, diry, pen_down, cur_x, cur_y, busy, done
  );
endinterface

// File: rtl/line_stepper.sv
// Bresenham line stepper: one axis step command per tick, pen settle before drawing.
// Start is accepted only in IDLE (ignored otherwise); done pulses one clk after the end tick.
module line_stepper #(
  parameter int W          = 9,
  parameter int PEN_SETTLE = 4
) (
  input  logic          clk,
  input  logic          rst,
  line_stepper_if.slave io_bus
);
  localparam int CW = (PEN_SETTLE < 2) ? 1 : $clog2(PEN_SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((PEN_SETTLE > 0) ? PEN_SETTLE - 1 : 0);
  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_STEP, S_FIN} state_t;
  state_t r_state, w_next;

  logic                r_pen, r_pen_down, r_pen_chg, r_sx_neg, r_sy_neg;
  logic [W-1:0]        r_x0, r_y0, r_x1, r_y1;
  logic [W-1:0]        r_cur_x, r_cur_y, r_dx, r_dy;
  logic signed [W+1:0] r_err;
  logic [CW-1:0]       r_cnt;
  logic [1:0]          r_dirx, r_diry;

  logic                w_settle_skip, w_at_end, w_step_x, w_step_y;
  logic [W-1:0]        w_dx, w_dy;
  logic signed [W+2:0] w_e2, w_dx_s, w_dy_s;
  logic signed [W+1:0] w_dx_e, w_dy_e, w_err_nxt;

  assign w_dx = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
  assign w_dy = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);

  assign w_settle_skip = (PEN_SETTLE == 0) || !r_pen_chg;
  assign w_at_end      = (r_cur_x == r_x1) && (r_cur_y == r_y1);

  // Error term and its doubled form stay wide enough that no compare can overflow.
  assign w_e2      = {r_err, 1'b0};
  assign w_dx_s    = {3'b000, r_dx};
  assign w_dy_s    = {3'b000, r_dy};
  assign w_dx_e    = {2'b00, r_dx};
  assign w_dy_e    = {2'b00, r_dy};
  assign w_step_x  = (w_e2 > -w_dy_s);
  assign w_step_y  = (w_e2 < w_dx_s);
  assign w_err_nxt = r_err - (w_step_x ? w_dy_e : '0) + (w_step_y ? w_dx_e : '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (io_bus.start) w_next = S_LOAD;
      S_LOAD:   w_next = S_SETTLE;
      S_SETTLE: if (w_settle_skip || (io_bus.tick && r_cnt == SETTLE_LAST)) w_next = S_STEP;
      S_STEP:   if (io_bus.tick && w_at_end) w_next = S_FIN;
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pen      <= 1'b0;
      r_pen_down <= 1'b0;
      r_pen_chg  <= 1'b0;
      r_sx_neg   <= 1'b0;
      r_sy_neg   <= 1'b0;
      r_x0       <= '0;
      r_y0       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_err      <= '0;
      r_cnt      <= '0;
      r_dirx     <= DIR_HOLD;
      r_diry     <= DIR_HOLD;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_pen <= io_bus.pen;
            r_x0  <= io_bus.x0;
            r_y0  <= io_bus.y0;
            r_x1  <= io_bus.x1;
            r_y1  <= io_bus.y1;
          end
        end
        S_LOAD: begin
          r_cur_x    <= r_x0;
          r_cur_y    <= r_y0;
          r_dx       <= w_dx;
          r_dy       <= w_dy;
          r_sx_neg   <= (r_x1 < r_x0);
          r_sy_neg   <= (r_y1 < r_y0);
          r_err      <= $signed({2'b00, w_dx}) - $signed({2'b00, w_dy});
          r_pen_chg  <= (r_pen_down != r_pen);
          r_pen_down <= r_pen;
          r_cnt      <= '0;
        end
        S_SETTLE: begin
          if (io_bus.tick && !w_settle_skip) r_cnt <= r_cnt + CW'(1);
        end
        S_STEP: begin
          if (io_bus.tick) begin
            if (w_at_end) begin
              r_dirx <= DIR_HOLD;
              r_diry <= DIR_HOLD;
            end else begin
              r_err  <= w_err_nxt;
              r_dirx <= w_step_x ? (r_sx_neg ? DIR_NEG : DIR_POS) : DIR_HOLD;
              r_diry <= w_step_y ? (r_sy_neg ? DIR_NEG : DIR_POS) : DIR_HOLD;
              if (w_step_x) r_cur_x <= r_sx_neg ? (r_cur_x - W'(1)) : (r_cur_x + W'(1));
              if (w_step_y) r_cur_y <= r_sy_neg ? (r_cur_y - W'(1)) : (r_cur_y + W'(1));
            end
          end
        end
        S_FIN: begin
          r_dirx <= DIR_HOLD;
          r_diry <= DIR_HOLD;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.dirx     = r_dirx;
  assign io_bus.diry     = r_diry;
  assign io_bus.pen_down = r_pen_down;
  assign io_bus.cur_x    = r_cur_x;
  assign io_bus.cur_y    = r_cur_y;
  assign io_bus.busy     = (r_state == S_LOAD) || (r_state == S_SETTLE) || (r_state == S_STEP);
  assign io_bus.done     = (r_state == S_FIN);
endmodule

// File: tb/tb_line_stepper.sv
// Bench for line_stepper: segment table driven through a Bresenham reference scoreboard,
// plus hand sequences for ignored restart and mid-segment reset.
module tb_line_stepper;
  localparam int W  = 9;
  localparam int PS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_stepper_if #(.W(W)) bus();
  line_stepper #(.W(W), .PEN_SETTLE(PS)) dut (.clk(clk), .rst(rst), .io_bus(bus));

  typedef struct {
    logic pen;
    int   x0, y0, x1, y1;
    int   settle, steps, ysteps;
  } vec_t;

  typedef struct {
    logic [1:0] dx, dy;
    int         x, y;
  } exp_t;

  vec_t vecs[7];
  exp_t exp_q[$];
  int   ys_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", tag, name, act, req);
    end
  endtask

  // Reference Bresenham walk; one entry per expected step tick.
  task automatic model_push(input int x0, input int y0, input int x1, input int y1);
    int x, y, dx, dy, sx, sy, err, e2;
    exp_t e;
    x  = x0;
    y  = y0;
    dx = (x1 >= x0) ? x1 - x0 : x0 - x1;
    dy = (y1 >= y0) ? y1 - y0 : y0 - y1;
    sx = (x1 >= x0) ? 1 : -1;
    sy = (y1 >= y0) ? 1 : -1;
    err = dx - dy;
    exp_q.delete();
    while (!(x == x1 && y == y1)) begin
      e2   = 2 * err;
      e.dx = 2'b00;
      e.dy = 2'b00;
      if (e2 > -dy) begin err -= dy; x += sx; e.dx = (sx > 0) ? 2'b01 : 2'b10; end
      if (e2 < dx)  begin err += dx; y += sy; e.dy = (sy > 0) ? 2'b01 : 2'b10; end
      e.x = x;
      e.y = y;
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge; start is driven in that same cycle.
  task automatic run_seg(input string tag, input logic pen, input int x0, input int y0,
                         input int x1, input int y1, input int settle, input int steps,
                         input int ysteps, input int inj_tick);
    int ticks, nsteps, nys, budget;
    bit finished;
    logic [1:0] ex_dx, ex_dy;
    exp_t e;
    model_push(x0, y0, x1, y1);
    ys_q.delete();
    bus.start = 1'b1;
    bus.pen   = pen;
    bus.x0 = W'(x0); bus.y0 = W'(y0); bus.x1 = W'(x1); bus.y1 = W'(y1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.pen   = ~pen;
    bus.x0 = W'(77); bus.y0 = W'(88); bus.x1 = W'(99); bus.y1 = W'(111);
    chk(tag, "busy_done_after_start", {bus.busy, bus.done}, 2'b10);
    @(negedge clk);
    chk(tag, "pen_cur_after_load", {bus.pen_down, bus.cur_x, bus.cur_y}, {pen, W'(x0), W'(y0)});
    @(negedge clk);
    ticks = 0; nsteps = 0; nys = 0; finished = 1'b0;
    budget = settle + steps + 4;
    while (!finished && ticks < budget) begin
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      ticks++;
      if (ticks <= settle) begin
        ex_dx = 2'b00; ex_dy = 2'b00;
        chk(tag, "settle", {bus.dirx, bus.diry, bus.cur_x, bus.cur_y}, {4'b0000, W'(x0), W'(y0)});
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ex_dx = e.dx; ex_dy = e.dy;
        chk(tag, "step", {bus.dirx, bus.diry, bus.cur_x, bus.cur_y}, {e.dx, e.dy, W'(e.x), W'(e.y)});
        if (bus.dirx != 2'b00 || bus.diry != 2'b00) nsteps++;
        if (bus.diry != 2'b00) nys++;
        ys_q.push_back(int'(bus.cur_y));
      end else begin
        chk(tag, "end_dir_done_busy", {bus.dirx, bus.diry, bus.done, bus.busy}, 6'b000010);
        chk(tag, "end_pos", {bus.cur_x, bus.cur_y}, {W'(x1), W'(y1)});
        @(negedge clk);
        chk(tag, "done_one_clk", {bus.done, bus.busy}, 2'b00);
        finished = 1'b1;
      end
      if (!finished) begin
        if (ticks == inj_tick) begin
          bus.start = 1'b1;
          bus.pen   = ~pen;
          bus.x0 = W'(100); bus.y0 = W'(100); bus.x1 = W'(0); bus.y1 = W'(0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk(tag, "hold_between_ticks", {bus.dirx, bus.diry, bus.done}, {ex_dx, ex_dy, 1'b0});
      end
    end
    chk(tag, "finished_in_budget", finished, 1'b1);
    chk(tag, "step_count", nsteps, steps);
    chk(tag, "y_step_count", nys, ysteps);
  endtask

  initial begin
    int exp_ys[5];
    vecs[0] = '{1'b1,   0,   0,   4,   0, 4,   4,   0};
    vecs[1] = '{1'b1,  10,  10,   7,  13, 0,   3,   3};
    vecs[2] = '{1'b1,   0,   0,   5,   2, 0,   5,   2};
    vecs[3] = '{1'b1,   3,   3,   3,   3, 0,   0,   0};
    vecs[4] = '{1'b0,  20,   5,  20,   1, 4,   4,   4};
    vecs[5] = '{1'b0, 511,   0,   0,   3, 0, 511,   3};
    vecs[6] = '{1'b1,   0, 511, 511,   0, 4, 511, 511};
    exp_ys  = '{0, 1, 1, 2, 2};

    rst = 1'b1;
    bus.tick = 1'b0; bus.start = 1'b0; bus.pen = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
    repeat (3) @(negedge clk);
    chk("reset", "outputs", {bus.dirx, bus.diry, bus.pen_down, bus.cur_x, bus.cur_y, bus.busy, bus.done}, '0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_seg($sformatf("vec%0d", i), vecs[i].pen, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1,
              vecs[i].settle, vecs[i].steps, vecs[i].ysteps, -1);
      if (i == 2) begin
        for (int k = 0; k < 5; k++)
          chk("vec2", $sformatf("cur_y_seq%0d", k), (k < ys_q.size()) ? ys_q[k] : -1, exp_ys[k]);
      end
      repeat (2) @(negedge clk);
    end

    run_seg("restart_ignored", 1'b1, 0, 0, 6, 0, 0, 6, 0, 2);
    repeat (2) @(negedge clk);

    bus.start = 1'b1; bus.pen = 1'b1;
    bus.x0 = W'(0); bus.y0 = W'(0); bus.x1 = W'(8); bus.y1 = W'(8);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    chk("mid_rst", "first_step", {bus.dirx, bus.diry, bus.cur_x, bus.cur_y}, {4'b0101, W'(1), W'(1)});
    @(negedge clk);
    bus.tick = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    chk("mid_rst", "outputs", {bus.dirx, bus.diry, bus.pen_down, bus.cur_x, bus.cur_y, bus.busy, bus.done}, '0);
    rst = 1'b0;
    run_seg("after_rst", 1'b1, 2, 2, 5, 4, 4, 3, 2, -1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
